send_packet_builder: RTL
========================

// Module: send_packet_builder
// PURPOSE
//  Downstream of the send-packet arbiter. Takes the arbitrated PID and write strobe, plus token fields.
//  Serialises the packet header into a byte stream for the USB byte transmitter.
//  Tokens (OUT/IN/SETUP/SOF) get a PID byte, 11-bit field and CRC5; handshakes get the PID byte only.
//  For DATA0/1 it opens the packet with the PID byte; the data path supplies payload and the end marker.
// PARAMETERS
//  none (PID codes and control encodings are fixed by USB 1.1; kept in a shared package)
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset, synchronous, active-high
//  sendPacketWEn    in   1   request strobe from arbiter; accepted only when sendPacketRdy=1
//  sendPacketPID    in   4   PID of packet to send
//  txAddr           in   7   device address (token packets)
//  txEndP           in   4   endpoint (token packets)
//  frameNum         in   11  frame number (SOF)
//  sendPacketRdy    out  1   1 = idle, can accept a request
//  txByteRdy        in   1   byte transmitter can take a byte this cycle
//  txByteWEn        out  1   byte write strobe
//  txByte           out  8   byte to transmit
//  txByteCtrl       out  2   00 DATA, 01 START (SYNC precedes), 10 STOP (EOP follows), 11 START+STOP
// BEHAVIOUR
//  - States: IDLE, S_PID, S_B1, S_B2. Reset -> IDLE; sendPacketRdy=0 while rst=1, txByteWEn=0.
//  - IDLE: sendPacketRdy=1. On sendPacketWEn=1:
//      latch PID, field (SOF: frameNum; token: {txEndP,txAddr}) and class; go to S_PID.
//    sendPacketWEn while busy is ignored; no queuing.
//  - txByteWEn = (state in S_PID/S_B1/S_B2) & txByteRdy. The state advances only on a write cycle.
//    If txByteRdy stays high, back-to-back writes occur on consecutive cycles.
//  - S_PID: txByte={~PID,PID}.
//      token: ctrl=01 -> S_B1; handshake (ACK 2,NAK A,STALL E) and PRE C: ctrl=11 -> IDLE;
//      DATA0 3/DATA1 B: ctrl=01 -> IDLE; reserved PID 0: ctrl=11 -> IDLE.
//  - S_B1: txByte=field[7:0], ctrl=00 -> S_B2.
//  - S_B2: txByte={crc[0],crc[1],crc[2],crc[3],crc[4],field[10:8]}, ctrl=10 -> IDLE.
//  - CRC5: c=5'b11111; per field bit d, LSB first: fb=c[4]^d; c={c[3:0],1'b0}^(fb?5'b00101:0);
//    crc=~c. Computed combinationally from the latched field; no added latency.
//  - Latency: request accepted in cycle N -> first txByteWEn earliest N+1.
//    Token done earliest N+3; sendPacketRdy=1 the cycle after the last write.
//  - Latched PID/fields are stable for the whole packet; input changes after accept have no effect.
//  - rst mid-packet: return to IDLE next edge; no further txByteWEn; the partial packet is abandoned.
//  - Simultaneous last-byte write and new request: the request is not accepted (Rdy=0 that cycle).
// STRUCTURE
//  - Package usb_pkt_pkg: PID constants (OUT 1, IN 9, SOF 5, SETUP D, DATA0 3, DATA1 B, ACK 2, NAK A,
//    STALL E, PRE C), txByteCtrl encodings, FSM state encoding.
//  - Sub-module usb_crc5 (combinational, 11-bit in, 5-bit out), reusable by the receive checker.
// TESTING
//  - SETUP (PID D), addr 0, ep 0, txByteRdy=1 -> bytes 2D/01, 00/00, 10/10 on 3 consecutive cycles.
//  - SOF (PID 5), frameNum 0 -> A5/01, 00/00, 10/10; frameNum 0x7FF -> second byte FF, byte3[2:0]=111.
//  - ACK (PID 2) -> single byte D2, ctrl 11; sendPacketRdy=1 on the next cycle.
//  - IN (PID 9) token with txByteRdy low 3 cycles before each byte -> exactly 3 strobes, values unchanged.
//  - sendPacketWEn pulsed during S_B1 with different PID -> ignored; the current packet completes intact.
//  - rst asserted in S_B1 -> no more strobes; sendPacketRdy=1 the cycle after rst drops.

Source files
------------

// File: rtl/usb_pkt_pkg.sv
// Shared USB 1.1 packet constants: PID codes, byte-transmitter control codes,
// packet-builder FSM states and the PID-to-packet-class mapping.
package usb_pkt_pkg;

    localparam logic [3:0] PID_RSVD  = 4'h0;
    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_PRE   = 4'hC;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [1:0] CTRL_DATA       = 2'b00;
    localparam logic [1:0] CTRL_START      = 2'b01;
    localparam logic [1:0] CTRL_STOP       = 2'b10;
    localparam logic [1:0] CTRL_START_STOP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PID,
        ST_B1,
        ST_B2
    } tx_state_t;

    // TOKEN: PID + field + CRC5; SINGLE: lone PID byte framed START+STOP;
    // DATA: PID byte opens the packet, the data path closes it.
    typedef enum logic [1:0] {
        CLS_TOKEN,
        CLS_SINGLE,
        CLS_DATA
    } pkt_class_t;

    function automatic pkt_class_t pid_class(input logic [3:0] pid);
        case (pid)
            PID_OUT, PID_IN, PID_SOF, PID_SETUP: pid_class = CLS_TOKEN;
            PID_DATA0, PID_DATA1:                pid_class = CLS_DATA;
            default:                             pid_class = CLS_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc5.sv
// Combinational USB token CRC5 over an 11-bit field, LSB first, result inverted.
module usb_crc5 (
    input  logic [10:0] i_data,
    output logic [4:0]  o_crc
);
    logic [4:0] w_c;
    logic       w_fb;

    always_comb begin
        w_c  = 5'b11111;
        w_fb = 1'b0;
        for (int i = 0; i < 11; i++) begin
            w_fb = w_c[4] ^ i_data[i];
            w_c  = {w_c[3:0], 1'b0} ^ (w_fb ? 5'b00101 : 5'b00000);
        end
        o_crc = ~w_c;
    end

endmodule

// File: rtl/send_packet_builder.sv
// Serialises USB packet headers (token / handshake / data PID) into the byte
// transmitter stream, one byte per accepted txByteRdy cycle.
module send_packet_builder
    import usb_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sendPacketWEn,
    input  logic [3:0]  sendPacketPID,
    input  logic [6:0]  txAddr,
    input  logic [3:0]  txEndP,
    input  logic [10:0] frameNum,
    output logic        sendPacketRdy,
    input  logic        txByteRdy,
    output logic        txByteWEn,
    output logic [7:0]  txByte,
    output logic [1:0]  txByteCtrl
);
    tx_state_t  r_state;
    tx_state_t  w_next;
    logic [3:0] r_pid;
    logic [10:0] r_field;
    pkt_class_t r_cls;
    logic [4:0] w_crc;
    logic       w_busy;
    logic       w_accept;
    logic       w_wr;

    assign sendPacketRdy = (r_state == ST_IDLE) && !rst;
    assign w_accept      = sendPacketRdy && sendPacketWEn;
    assign w_busy        = (r_state != ST_IDLE);
    assign txByteWEn     = w_busy && txByteRdy && !rst;
    assign w_wr          = txByteWEn;

    usb_crc5 u_crc5 (
        .i_data (r_field),
        .o_crc  (w_crc)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Header fields are captured once and held for the whole packet.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pid   <= sendPacketPID;
            r_field <= (sendPacketPID == PID_SOF) ? frameNum : {txEndP, txAddr};
            r_cls   <= pid_class(sendPacketPID);
        end
    end

    always_comb begin
        w_next     = r_state;
        txByte     = 8'h00;
        txByteCtrl = CTRL_DATA;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_PID;
            end
            ST_PID: begin
                txByte = {~r_pid, r_pid};
                case (r_cls)
                    CLS_TOKEN: begin
                        txByteCtrl = CTRL_START;
                        if (w_wr) w_next = ST_B1;
                    end
                    CLS_DATA: begin
                        txByteCtrl = CTRL_START;
                        if (w_wr) w_next = ST_IDLE;
                    end
                    default: begin
                        txByteCtrl = CTRL_START_STOP;
                        if (w_wr) w_next = ST_IDLE;
                    end
                endcase
            end
            ST_B1: begin
                txByte     = r_field[7:0];
                txByteCtrl = CTRL_DATA;
                if (w_wr) w_next = ST_B2;
            end
            ST_B2: begin
                txByte     = {w_crc[0], w_crc[1], w_crc[2], w_crc[3], w_crc[4], r_field[10:8]};
                txByteCtrl = CTRL_STOP;
                if (w_wr) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
